param_datapath: RTL and testbench

PARAM_DATAPATH -- requirements
Module: param_datapath

---
 rtl/param_datapath_if.sv | 31 +++
 rtl/param_datapath.sv | 142 ++++++++++++++
 tb/tb_param_datapath.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/param_datapath_if.sv
// Command/result bundle for param_datapath: command handshake plus the
// registered result strobe and flags.
interface param_datapath_if #(
  parameter int WIDTH = 16,
  parameter int NREG  = 4
);
  localparam int SW = (NREG > 1) ? $clog2(NREG) : 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic [3:0]       cmd_op;
  logic [SW-1:0]    cmd_xsel;
  logic [SW-1:0]    cmd_ysel;
  logic [SW-1:0]    cmd_dst;
  logic [WIDTH-1:0] mem_data;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic             res_carry;

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_xsel, cmd_ysel, cmd_dst, mem_data,
    input  cmd_ready, res_valid, res_data, res_zero, res_carry
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_xsel, cmd_ysel, cmd_dst, mem_data,
    output cmd_ready, res_valid, res_data, res_zero, res_carry
  );
endinterface

// File: rtl/param_datapath.sv
// Register-file datapath: accept -> EXEC -> WB, one command per two cycles,
// with write-back forwarding and a hardwired-zero register 0.
module param_datapath #(
  parameter int WIDTH = 16,
  parameter int NREG  = 4
) (
  input logic             clk,
  input logic             rst_n,
  param_datapath_if.slave bus
);
  localparam int SW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] x_rd, y_rd;

  logic [3:0]       op_p1;
  logic             load_p1;
  logic [SW-1:0]    dst_p1;
  logic [WIDTH-1:0] mem_p1, x_p1, y_p1;

  logic [WIDTH:0]   alu_out;
  logic [WIDTH-1:0] res_nxt;
  logic             carry_nxt;

  logic [WIDTH-1:0] res_p2;
  logic             zero_p2, carry_p2, vld_p2;

  // Result in the low WIDTH bits, carry/borrow in the top bit.
  function automatic logic [WIDTH:0] alu(input logic [3:0] op,
                                         input logic [WIDTH-1:0] x,
                                         input logic [WIDTH-1:0] y);
    logic [WIDTH:0] r;
    r = '0;
    case (op)
      4'd0:    r = {1'b0, x} + {1'b0, y};
      4'd1:    r = {1'b0, x} - {1'b0, y};
      4'd2:    r = {1'b0, x & y};
      4'd3:    r = {1'b0, x | y};
      4'd4:    r = {1'b0, x ^ y};
      4'd5:    r = {1'b0, ~x};
      4'd6:    r = {x, 1'b0};
      4'd7:    r = {x[0], 1'b0, x[WIDTH-1:1]};
      4'd8:    r = {1'b0, x};
      4'd9:    r = {1'b0, y};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == '0);
  endfunction

  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign bus.cmd_ready = rst_n && ((state == IDLE) || (state == WB));
  assign bus.res_valid = vld_p2;
  assign bus.res_data  = res_p2;
  assign bus.res_zero  = zero_p2;
  assign bus.res_carry = carry_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A command accepted in WB must see the value about to be written back.
  always_comb begin
    x_rd = regs[bus.cmd_xsel];
    y_rd = regs[bus.cmd_ysel];
    if (state == WB && dst_p1 != '0 && bus.cmd_xsel == dst_p1) x_rd = res_p2;
    if (state == WB && dst_p1 != '0 && bus.cmd_ysel == dst_p1) y_rd = res_p2;
  end

  // Stage p1: command and operands captured at the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_p1   <= '0;
      load_p1 <= 1'b0;
      dst_p1  <= '0;
      mem_p1  <= '0;
      x_p1    <= '0;
      y_p1    <= '0;
    end else if (accept) begin
      op_p1   <= bus.cmd_op;
      load_p1 <= bus.cmd_load;
      dst_p1  <= bus.cmd_dst;
      mem_p1  <= bus.mem_data;
      x_p1    <= x_rd;
      y_p1    <= y_rd;
    end
  end

  always_comb begin
    alu_out   = alu(op_p1, x_p1, y_p1);
    res_nxt   = alu_out[WIDTH-1:0];
    carry_nxt = alu_out[WIDTH];
    if (load_p1) begin
      res_nxt   = mem_p1;
      carry_nxt = 1'b0;
    end
  end

  // Stage p2: result registered on the EXEC->WB edge, valid for the WB cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p2   <= '0;
      zero_p2  <= 1'b0;
      carry_p2 <= 1'b0;
      vld_p2   <= 1'b0;
    end else begin
      vld_p2 <= (state == EXEC);
      if (state == EXEC) begin
        res_p2   <= res_nxt;
        zero_p2  <= is_zero(res_nxt);
        carry_p2 <= carry_nxt;
      end
    end
  end

  // Write-back on the edge leaving WB; register 0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state == WB && dst_p1 != '0) begin
      regs[dst_p1] <= res_p2;
    end
  end
endmodule

// File: tb/tb_param_datapath.sv
// Directed self-checking bench for param_datapath (WIDTH=16, NREG=4).
module tb_param_datapath;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  param_datapath_if #(.WIDTH(16), .NREG(4)) bus ();

  param_datapath #(.WIDTH(16), .NREG(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a command and returns just after the edge that accepted it.
  task automatic send(input string tag, input logic ld, input logic [3:0] op,
                      input logic [1:0] xs, input logic [1:0] ys, input logic [1:0] d,
                      input logic [15:0] md);
    int n;
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = ld;
    bus.cmd_op    = op;
    bus.cmd_xsel  = xs;
    bus.cmd_ysel  = ys;
    bus.cmd_dst   = d;
    bus.mem_data  = md;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".ready"}, bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Issues a command, checks the EXEC cycle, and returns in the WB cycle.
  task automatic op_chk(input string tag, input logic ld, input logic [3:0] op,
                        input logic [1:0] xs, input logic [1:0] ys, input logic [1:0] d,
                        input logic [15:0] md, input logic [15:0] ed,
                        input logic ez, input logic ec);
    send(tag, ld, op, xs, ys, d, md);
    @(negedge clk);
    chk({tag, ".exec_vld"}, bus.res_valid, 0);
    chk({tag, ".exec_rdy"}, bus.cmd_ready, 0);
    @(negedge clk);
    chk({tag, ".vld"},   bus.res_valid, 1);
    chk({tag, ".data"},  bus.res_data, ed);
    chk({tag, ".zero"},  bus.res_zero, ez);
    chk({tag, ".carry"}, bus.res_carry, ec);
    chk({tag, ".wb_rdy"}, bus.cmd_ready, 1);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = 4'd0;
    bus.cmd_xsel  = 2'd0;
    bus.cmd_ysel  = 2'd0;
    bus.cmd_dst   = 2'd0;
    bus.mem_data  = 16'h0000;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", bus.cmd_ready, 0);
    chk("rst.vld",   bus.res_valid, 0);
    chk("rst.data",  bus.res_data, 0);
    chk("rst.zero",  bus.res_zero, 0);
    chk("rst.carry", bus.res_carry, 0);
    rst_n = 1'b1;
    #1;
    chk("rel.ready", bus.cmd_ready, 1);

    // Loads and ADD with carry-out; the ADD forwards r2 from the pending load.
    op_chk("ld_r1",  1, 4'd0, 0, 0, 1, 16'h00FF, 16'h00FF, 0, 0);
    op_chk("ld_r2",  1, 4'd0, 0, 0, 2, 16'hFF01, 16'hFF01, 0, 0);
    op_chk("add_c",  0, 4'd0, 1, 2, 3, 16'h0000, 16'h0000, 1, 1);
    gap(2);
    op_chk("rd_r1",  0, 4'd8, 1, 0, 0, 16'h0000, 16'h00FF, 0, 0);

    // SUB with borrow, then read back the stored result after idle cycles.
    op_chk("ld1_s",  1, 4'd0, 0, 0, 1, 16'h0001, 16'h0001, 0, 0);
    op_chk("ld2_s",  1, 4'd0, 0, 0, 2, 16'h0002, 16'h0002, 0, 0);
    op_chk("sub_b",  0, 4'd1, 1, 2, 3, 16'h0000, 16'hFFFF, 0, 1);
    gap(3);
    op_chk("rd_r3",  0, 4'd9, 0, 3, 0, 16'h0000, 16'hFFFF, 0, 0);

    // Forwarding of both operands from a load in its WB cycle.
    gap(1);
    op_chk("ld_fw",  1, 4'd0, 0, 0, 1, 16'h1234, 16'h1234, 0, 0);
    op_chk("add_fw", 0, 4'd0, 1, 1, 2, 16'h0000, 16'h2468, 0, 0);

    // r0 is hardwired to zero and never forwarded.
    op_chk("ld_r0",  1, 4'd0, 0, 0, 0, 16'hABCD, 16'hABCD, 0, 0);
    op_chk("pass_r0", 0, 4'd8, 0, 0, 1, 16'h0000, 16'h0000, 1, 0);

    // Remaining ALU ops on r1=0x8001, r2=0x0F0F.
    op_chk("ld_a",   1, 4'd0, 0, 0, 1, 16'h8001, 16'h8001, 0, 0);
    op_chk("ld_b",   1, 4'd0, 0, 0, 2, 16'h0F0F, 16'h0F0F, 0, 0);
    op_chk("and",    0, 4'd2, 1, 2, 3, 16'h0000, 16'h0001, 0, 0);
    op_chk("or",     0, 4'd3, 1, 2, 3, 16'h0000, 16'h8F0F, 0, 0);
    op_chk("xor",    0, 4'd4, 1, 2, 3, 16'h0000, 16'h8F0E, 0, 0);
    op_chk("not",    0, 4'd5, 1, 2, 3, 16'h0000, 16'h7FFE, 0, 0);
    op_chk("shl",    0, 4'd6, 1, 2, 3, 16'h0000, 16'h0002, 0, 1);
    op_chk("shr",    0, 4'd7, 1, 2, 3, 16'h0000, 16'h4000, 0, 1);
    op_chk("shr_b",  0, 4'd7, 2, 1, 3, 16'h0000, 16'h0787, 0, 1);
    op_chk("add_nc", 0, 4'd0, 1, 2, 3, 16'h0000, 16'h8F10, 0, 0);
    op_chk("sub_nb", 0, 4'd1, 1, 2, 3, 16'h0000, 16'h70F2, 0, 0);
    op_chk("op12",   0, 4'd12, 1, 2, 3, 16'h0000, 16'h0000, 1, 0);
    op_chk("ld_ign", 1, 4'd6, 1, 2, 3, 16'h8000, 16'h8000, 0, 0);

    // Backpressure: cmd_valid held high across three commands.
    gap(2);
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b1;
    bus.cmd_op    = 4'd0;
    bus.cmd_xsel  = 2'd0;
    bus.cmd_ysel  = 2'd0;
    bus.cmd_dst   = 2'd1;
    bus.mem_data  = 16'h1111;
    chk("bp.idle_rdy", bus.cmd_ready, 1);
    @(negedge clk);
    chk("bp.a_exec_rdy", bus.cmd_ready, 0);
    chk("bp.a_exec_vld", bus.res_valid, 0);
    bus.cmd_dst  = 2'd2;
    bus.mem_data = 16'h2222;
    @(negedge clk);
    chk("bp.a_vld",  bus.res_valid, 1);
    chk("bp.a_data", bus.res_data, 16'h1111);
    chk("bp.a_rdy",  bus.cmd_ready, 1);
    @(negedge clk);
    chk("bp.b_exec_rdy", bus.cmd_ready, 0);
    chk("bp.b_exec_vld", bus.res_valid, 0);
    bus.cmd_load = 1'b0;
    bus.cmd_op   = 4'd0;
    bus.cmd_xsel = 2'd1;
    bus.cmd_ysel = 2'd2;
    bus.cmd_dst  = 2'd3;
    @(negedge clk);
    chk("bp.b_vld",  bus.res_valid, 1);
    chk("bp.b_data", bus.res_data, 16'h2222);
    chk("bp.b_rdy",  bus.cmd_ready, 1);
    @(negedge clk);
    chk("bp.c_exec_rdy", bus.cmd_ready, 0);
    chk("bp.c_exec_vld", bus.res_valid, 0);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp.c_vld",  bus.res_valid, 1);
    chk("bp.c_data", bus.res_data, 16'h3333);
    @(negedge clk);
    chk("bp.idle_vld", bus.res_valid, 0);
    chk("bp.idle_rdy2", bus.cmd_ready, 1);

    // Reset asserted during the WB cycle of a load to r1.
    op_chk("ld_rst", 1, 4'd0, 0, 0, 1, 16'h5555, 16'h5555, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.vld",   bus.res_valid, 0);
    chk("mid_rst.data",  bus.res_data, 0);
    chk("mid_rst.ready", bus.cmd_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst.ready", bus.cmd_ready, 1);
    @(negedge clk);
    chk("post_rst.vld", bus.res_valid, 0);
    op_chk("post_r1", 0, 4'd8, 1, 0, 0, 16'h0000, 16'h0000, 1, 0);
    op_chk("post_r2", 0, 4'd9, 0, 2, 0, 16'h0000, 16'h0000, 1, 0);

    gap(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
